// File: rtl/issue_scoreboard.sv
// Register scoreboard for the issue stage: tracks destination registers with writes in flight
// and holds an instruction on RAW/WAW hazards or when too many writes are outstanding.
module issue_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reads_0,
  input  logic        reads_1,
  input  logic [4:0]  read_reg_0,
  input  logic [4:0]  read_reg_1,
  input  logic        writes,
  input  logic [4:0]  write_reg,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic        flush,
  output logic [31:0] pending,
  output logic [2:0]  inflight_count,
  output logic [15:0] stall_count
);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] stall_q, stall_d;

  logic        wb_hit;
  logic [31:0] pend_eff;
  logic [2:0]  cnt_eff;
  logic        hazard;
  logic        cnt_ok;
  logic        fire;
  logic        alloc;

  // A completing writeback is bypassed into the hazard check so a dependent can issue this cycle.
  always_comb begin
    wb_hit   = wb_valid & pending_q[wb_reg];
    pend_eff = pending_q;
    if (wb_hit) begin
      pend_eff[wb_reg] = 1'b0;
    end
    cnt_eff  = count_q - {2'b00, wb_hit};
    hazard   = (reads_0 & pend_eff[read_reg_0]) |
               (reads_1 & pend_eff[read_reg_1]) |
               (writes  & pend_eff[write_reg]);
    cnt_ok   = ~writes | (cnt_eff < 3'(MAX_INFLIGHT));
    in_ready = ~flush & ~hazard & cnt_ok;
    fire     = in_valid & in_ready;
    alloc    = fire & writes;
  end

  always_comb begin
    pending_d = pend_eff;
    count_d   = cnt_eff + {2'b00, alloc};
    if (alloc) begin
      pending_d[write_reg] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
      count_d   = '0;
    end
    stall_d = stall_q;
    if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
      stall_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
    end
  end

  assign pending        = pending_q;
  assign inflight_count = count_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reads_0 = 1'b0;
  logic        reads_1 = 1'b0;
  logic [4:0]  read_reg_0 = '0;
  logic [4:0]  read_reg_1 = '0;
  logic        writes = 1'b0;
  logic [4:0]  write_reg = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic [31:0] pending;
  logic [2:0]  inflight_count;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .reads_0        (reads_0),
    .reads_1        (reads_1),
    .read_reg_0     (read_reg_0),
    .read_reg_1     (read_reg_1),
    .writes         (writes),
    .write_reg      (write_reg),
    .wb_valid       (wb_valid),
    .wb_reg         (wb_reg),
    .flush          (flush),
    .pending        (pending),
    .inflight_count (inflight_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    reads_0   = 1'b0;
    reads_1   = 1'b0;
    writes    = 1'b0;
    wb_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic issue_write(input logic [4:0] r);
    idle();
    in_valid  = 1'b1;
    writes    = 1'b1;
    write_reg = r;
  endtask

  // Count must always equal the number of pending registers.
  always @(negedge clk) begin
    if (!rst) check("popcount", 32'(inflight_count), 32'($countones(pending)));
  end

  initial begin
    #1;
    check("rst_pending", pending, 32'h0);
    check("rst_count", 32'(inflight_count), 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);
    #12 rst = 1'b0;
    step();

    // RAW on r5
    issue_write(5'd5);
    #1 check("w5_ready", 32'(in_ready), 32'h1);
    step();
    idle();
    in_valid = 1'b1; reads_0 = 1'b1; read_reg_0 = 5'd5;
    #1 check("raw5_ready", 32'(in_ready), 32'h0);
    check("raw5_pending", pending, 32'h20);
    step();
    check("raw5_stall1", 32'(stall_count), 32'h1);
    step();
    check("raw5_stall2", 32'(stall_count), 32'h2);

    // Same-cycle writeback bypass
    wb_valid = 1'b1; wb_reg = 5'd5;
    #1 check("bypass_ready", 32'(in_ready), 32'h1);
    step();
    idle();
    #1 check("bypass_pending", pending, 32'h0);
    check("bypass_stall", 32'(stall_count), 32'h2);

    // Fill to MAX_INFLIGHT
    for (int r = 1; r <= 4; r++) begin
      issue_write(5'(r));
      #1 check("fill_ready", 32'(in_ready), 32'h1);
      step();
    end
    idle();
    #1 check("fill_count", 32'(inflight_count), 32'h4);
    check("fill_pending", pending, 32'h1E);
    issue_write(5'd6);
    #1 check("full_w6_ready", 32'(in_ready), 32'h0);
    step();
    check("full_stall", 32'(stall_count), 32'h3);
    idle();
    in_valid = 1'b1; reads_0 = 1'b1; read_reg_0 = 5'd7;
    #1 check("full_read7_ready", 32'(in_ready), 32'h1);
    step();
    issue_write(5'd6);
    wb_valid = 1'b1; wb_reg = 5'd1;
    #1 check("wb1_w6_ready", 32'(in_ready), 32'h1);
    step();
    idle();
    #1 check("wb1_w6_count", 32'(inflight_count), 32'h4);
    check("wb1_w6_pending", pending, 32'h5C);

    // Drop to 3 pending, then flush
    wb_valid = 1'b1; wb_reg = 5'd2;
    step();
    idle();
    #1 check("pre_flush_pending", pending, 32'h58);
    in_valid = 1'b1; flush = 1'b1;
    #1 check("flush_ready", 32'(in_ready), 32'h0);
    step();
    idle();
    #1 check("flush_pending", pending, 32'h0);
    check("flush_count", 32'(inflight_count), 32'h0);
    check("flush_stall", 32'(stall_count), 32'h4);

    // Issue write r9 while r9 writes back; then writeback to non-pending r10
    issue_write(5'd9);
    step();
    check("w9_pending", pending, 32'h200);
    issue_write(5'd9);
    wb_valid = 1'b1; wb_reg = 5'd9;
    #1 check("w9_wb9_ready", 32'(in_ready), 32'h1);
    step();
    idle();
    #1 check("w9_wb9_pending", pending, 32'h200);
    check("w9_wb9_count", 32'(inflight_count), 32'h1);
    wb_valid = 1'b1; wb_reg = 5'd10;
    step();
    idle();
    #1 check("wb10_pending", pending, 32'h200);
    check("wb10_count", 32'(inflight_count), 32'h1);

    // Unflagged source field is don't-care
    in_valid = 1'b1; reads_0 = 1'b0; read_reg_0 = 5'd9; read_reg_1 = 5'd9;
    #1 check("dontcare_ready", 32'(in_ready), 32'h1);
    step();
    idle();
    in_valid = 1'b1; reads_1 = 1'b1; read_reg_1 = 5'd9;
    #1 check("raw9_port1_ready", 32'(in_ready), 32'h0);

    // Saturate stall counter
    for (int i = 0; i < 65540; i++) step();
    check("stall_sat", 32'(stall_count), 32'hFFFF);

    // Async reset mid-cycle while stalled
    #3 rst = 1'b1;
    #1 check("arst_pending", pending, 32'h0);
    check("arst_count", 32'(inflight_count), 32'h0);
    check("arst_stall", 32'(stall_count), 32'h0);
    check("arst_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    step();
    check("post_rst_stall", 32'(stall_count), 32'h0);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
